// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI front-end to TinyQV peripheral-bus bridge.
package spi_bridge_pkg;
    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10,
        W_NONE = 2'b11
    } txn_width_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ
    } bridge_state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam logic [1:0]  BUS_IDLE     = 2'b11;

    // Bits of peripheral read data kept for a given access width.
    function automatic logic [31:0] width_mask(input txn_width_t w);
        case (w)
            W_BYTE:  return 32'h0000_00FF;
            W_HALF:  return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction
endpackage

// File: rtl/rising_edge_detector.sv
// Rising-edge detector whose history only advances in enabled cycles.
module rising_edge_detector (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)    d_q <= 1'b0;
        else if (ena) d_q <= d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/spi_peri_bridge.sv
// Converts SPI register strobes into peripheral-bus writes and posted reads;
// a read frame returns the result of the previously completed read.
module spi_peri_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int REG_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [REG_W-1:0]  reg_data_o,
    input  logic              reg_data_o_dv,
    input  logic              reg_addr_v,
    input  logic              reg_rw,
    input  logic [1:0]        txn_width,
    output logic [REG_W-1:0]  reg_data_i,
    output logic [ADDR_W-1:0] per_address,
    output logic [REG_W-1:0]  per_data_in,
    output logic [1:0]        per_data_write_n,
    output logic [1:0]        per_data_read_n,
    input  logic [REG_W-1:0]  per_data_out,
    input  logic              per_data_ready,
    output logic              busy,
    output logic [1:0]        err
);
    bridge_state_t    state;
    txn_width_t       width, rd_width;
    logic [REG_W-1:0] pending;
    logic             pend_v;
    logic [7:0]       tcnt;
    logic             addr_rise;
    logic             unused_rw;

    assign width = txn_width_t'(txn_width);
    // Direction is already carried by which strobe fires.
    assign unused_rw = reg_rw;

    rising_edge_detector u_av_edge (
        .clk  (clk),
        .rstb (rstb),
        .ena  (ena),
        .d    (reg_addr_v),
        .rise (addr_rise)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state            <= S_IDLE;
            reg_data_i       <= '0;
            per_address      <= '0;
            per_data_in      <= '0;
            per_data_write_n <= BUS_IDLE;
            per_data_read_n  <= BUS_IDLE;
            busy             <= 1'b0;
            err              <= 2'b00;
            pending          <= '0;
            pend_v           <= 1'b0;
            tcnt             <= '0;
            rd_width         <= W_NONE;
        end else if (ena) begin
            // Hand-off to the transmit buffer only between frames; a capture
            // later in this block wins over the clear.
            if (pend_v && !reg_addr_v) begin
                reg_data_i <= pending;
                pend_v     <= 1'b0;
            end
            if (state != S_IDLE && (reg_data_o_dv || addr_rise))
                err[1] <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (reg_data_o_dv) begin
                        if (addr_rise) err[1] <= 1'b1;
                        if (width != W_NONE) begin
                            state            <= S_WRITE;
                            per_address      <= reg_addr;
                            per_data_in      <= reg_data_o;
                            per_data_write_n <= width;
                            busy             <= 1'b1;
                        end
                    end else if (addr_rise) begin
                        if (width == W_NONE) begin
                            pending <= '0;
                            pend_v  <= 1'b1;
                        end else begin
                            state           <= S_READ;
                            per_address     <= reg_addr;
                            per_data_read_n <= width;
                            rd_width        <= width;
                            tcnt            <= '0;
                            busy            <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    state            <= S_IDLE;
                    per_data_write_n <= BUS_IDLE;
                    busy             <= 1'b0;
                end
                S_READ: begin
                    if (per_data_ready) begin
                        pending         <= per_data_out & REG_W'(width_mask(rd_width));
                        pend_v          <= 1'b1;
                        state           <= S_IDLE;
                        per_data_read_n <= BUS_IDLE;
                        busy            <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        if (tcnt == 8'(TIMEOUT - 1)) begin
                            pending         <= REG_W'(TIMEOUT_DATA);
                            pend_v          <= 1'b1;
                            err[0]          <= 1'b1;
                            state           <= S_IDLE;
                            per_data_read_n <= BUS_IDLE;
                            busy            <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
